// File: rtl/pmu_hfosc_sequencer_pkg.sv
// Shared definitions for the HFOSC power sequencer.
// Contents:
//   hfosc_state_e    sequencer state encoding (OFF, PU_WAIT, ON, DRAIN)
//   hfosc_out_t      bundle of the four HF control/status outputs
//   DEF_* constants  default timing values
//   decode_outputs() maps a state to its output bundle
//   sat_inc16()      saturating 16-bit increment used by the wake counter
package pmu_hfosc_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_PU_WAIT = 2'd1,
        ST_ON      = 2'd2,
        ST_DRAIN   = 2'd3
    } hfosc_state_e;

    typedef struct packed {
        logic powerup;
        logic enable;
        logic ready;
        logic busy;
    } hfosc_out_t;

    localparam int unsigned DEF_PU_SETTLE_CYCLES = 100;
    localparam int unsigned DEF_EN_DRAIN_CYCLES  = 4;
    localparam int unsigned DEF_MIN_OFF_CYCLES   = 8;
    localparam int unsigned DEF_CNT_W            = 8;

    // Output pattern for each state; unknown encodings map to the safe all-off pattern.
    function automatic hfosc_out_t decode_outputs(input hfosc_state_e st);
        hfosc_out_t o;
        case (st)
            ST_OFF:     o = '{powerup: 1'b0, enable: 1'b0, ready: 1'b0, busy: 1'b0};
            ST_PU_WAIT: o = '{powerup: 1'b1, enable: 1'b0, ready: 1'b0, busy: 1'b1};
            ST_ON:      o = '{powerup: 1'b1, enable: 1'b1, ready: 1'b1, busy: 1'b0};
            ST_DRAIN:   o = '{powerup: 1'b1, enable: 1'b1, ready: 1'b0, busy: 1'b1};
            default:    o = '{powerup: 1'b0, enable: 1'b0, ready: 1'b0, busy: 1'b0};
        endcase
        return o;
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'hFFFF) begin
            r = v;
        end else begin
            r = v + 16'h0001;
        end
        return r;
    endfunction

endpackage

// File: rtl/pmu_hfosc_sequencer_sync_2ff.sv
// Two-flop synchronizer for a single level signal crossing into clk_i.
// Ports:
//   clk_i    destination clock
//   reset_i  synchronous active-high reset; both flops load RESET_VAL
//   d_i      asynchronous level input
//   q_o      synchronized level (two clk_i cycles of latency)
module pmu_hfosc_sequencer_sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Synchronizer chain; the first stage may go metastable, the second resolves it.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pmu_hfosc_sequencer.sv
// HFOSC power-up / enable / drain / power-down sequencer, clocked by the
// always-on low-frequency clock.
// Ports:
//   clk_i            always-on LF clock
//   reset_i          synchronous active-high reset
//   pwr_req_i        HF clock request from the PMU (asynchronous level)
//   clkhf_powerup_o  to HFOSC CLKHFPU
//   clkhf_enable_o   to HFOSC CLKHFEN
//   hf_ready_o       HF clock stable and usable (ON only)
//   seq_busy_o       transition in progress (PU_WAIT or DRAIN)
//   wake_count_o     ON entries since reset, saturating
module pmu_hfosc_sequencer
    import pmu_hfosc_sequencer_pkg::*;
#(
    parameter int unsigned PU_SETTLE_CYCLES = DEF_PU_SETTLE_CYCLES,
    parameter int unsigned EN_DRAIN_CYCLES  = DEF_EN_DRAIN_CYCLES,
    parameter int unsigned MIN_OFF_CYCLES   = DEF_MIN_OFF_CYCLES,
    parameter int unsigned CNT_W            = DEF_CNT_W,
    parameter logic        RESET_ON         = 1'b1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        pwr_req_i,
    output logic        clkhf_powerup_o,
    output logic        clkhf_enable_o,
    output logic        hf_ready_o,
    output logic        seq_busy_o,
    output logic [15:0] wake_count_o
);

    // Terminal counts. PU_WAIT and DRAIN count from zero, so their last
    // cycle is N-1; OFF saturates at MIN_OFF_CYCLES to mark the off-timer expired.
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(PU_SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(EN_DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_DONE    = CNT_W'(MIN_OFF_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    // Booting into ON leaves the off-timer irrelevant; booting into OFF pre-expires
    // it so the first request is honoured without an extra wait.
    localparam hfosc_state_e     RST_STATE = RESET_ON ? ST_ON : ST_OFF;
    localparam logic [CNT_W-1:0] RST_CNT   = RESET_ON ? CNT_ZERO : OFF_DONE;

    logic             req_s;
    hfosc_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      wake_q, wake_d;
    hfosc_out_t       outs_q, outs_d;

    pmu_hfosc_sequencer_sync_2ff #(
        .RESET_VAL (RESET_ON)
    ) u_req_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .d_i     (pwr_req_i),
        .q_o     (req_s)
    );

    // Next-state, shared timer and wake counter update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wake_d  = wake_q;
        case (state_q)
            ST_OFF: begin
                if (req_s && (cnt_q == OFF_DONE)) begin
                    state_d = ST_PU_WAIT;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q < OFF_DONE) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    // Clamp also recovers from any out-of-range count.
                    cnt_d = OFF_DONE;
                end
            end
            ST_PU_WAIT: begin
                if (!req_s) begin
                    // Abort before enable is ever asserted.
                    state_d = ST_OFF;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_ON;
                    cnt_d   = CNT_ZERO;
                    wake_d  = sat_inc16(wake_q);
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_ON: begin
                if (!req_s) begin
                    state_d = ST_DRAIN;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = CNT_ZERO;
                end
            end
            ST_DRAIN: begin
                if (req_s) begin
                    // Oscillator never stopped, so re-acquire skips the settle wait.
                    state_d = ST_ON;
                    cnt_d   = CNT_ZERO;
                    wake_d  = sat_inc16(wake_q);
                end else if (cnt_q == DRAIN_LAST) begin
                    state_d = ST_OFF;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_OFF;
                cnt_d   = CNT_ZERO;
            end
        endcase
        // Outputs are registered from the next state so they align with state_q.
        outs_d = decode_outputs(state_d);
    end

    // State, timer, wake counter and output registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= RST_STATE;
            cnt_q   <= RST_CNT;
            wake_q  <= 16'h0000;
            outs_q  <= decode_outputs(RST_STATE);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wake_q  <= wake_d;
            outs_q  <= outs_d;
        end
    end

    assign clkhf_powerup_o = outs_q.powerup;
    assign clkhf_enable_o  = outs_q.enable;
    assign hf_ready_o      = outs_q.ready;
    assign seq_busy_o      = outs_q.busy;
    assign wake_count_o    = wake_q;

endmodule

// File: tb/tb_pmu_hfosc_sequencer.sv
// Self-checking bench for pmu_hfosc_sequencer. Two instances share the clock:
// dut0 boots into OFF, dut1 boots into ON. Each vector drives reset/request of
// one instance, pushes its expectation to a queue, advances N clocks and pops
// the expectation for comparison on the falling edge.
module tb_pmu_hfosc_sequencer;

    typedef struct {
        logic        sel;       // 0: dut0 (RESET_ON=0), 1: dut1 (RESET_ON=1)
        logic        rst;
        logic        req;
        int          n;         // rising edges to advance before checking
        logic [3:0]  exp_o;     // {powerup, enable, ready, busy}
        logic [15:0] exp_wake;
        string       name;
    } vec_t;

    logic        clk;
    logic        reset0, req0, reset1, req1;
    logic        pu0, en0, rdy0, busy0;
    logic        pu1, en1, rdy1, busy1;
    logic [15:0] wake0, wake1;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;

    vec_t vecs[$];
    vec_t exp_q[$];

    pmu_hfosc_sequencer #(
        .PU_SETTLE_CYCLES (10),
        .EN_DRAIN_CYCLES  (4),
        .MIN_OFF_CYCLES   (8),
        .CNT_W            (8),
        .RESET_ON         (1'b0)
    ) dut0 (
        .clk_i           (clk),
        .reset_i         (reset0),
        .pwr_req_i       (req0),
        .clkhf_powerup_o (pu0),
        .clkhf_enable_o  (en0),
        .hf_ready_o      (rdy0),
        .seq_busy_o      (busy0),
        .wake_count_o    (wake0)
    );

    pmu_hfosc_sequencer #(
        .PU_SETTLE_CYCLES (10),
        .EN_DRAIN_CYCLES  (4),
        .MIN_OFF_CYCLES   (8),
        .CNT_W            (8),
        .RESET_ON         (1'b1)
    ) dut1 (
        .clk_i           (clk),
        .reset_i         (reset1),
        .pwr_req_i       (req1),
        .clkhf_powerup_o (pu1),
        .clkhf_enable_o  (en1),
        .hf_ready_o      (rdy1),
        .seq_busy_o      (busy1),
        .wake_count_o    (wake1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    // Invariants on both instances: enable implies powerup, ready implies enable.
    always @(negedge clk) begin
        if (mon_en) begin
            checks = checks + 2;
            if ((en0 && !pu0) || (rdy0 && !en0)) begin
                errors = errors + 1;
                $display("FAIL invariant_dut0: got pu=%b en=%b rdy=%b required en=>pu and rdy=>en",
                         pu0, en0, rdy0);
            end
            if ((en1 && !pu1) || (rdy1 && !en1)) begin
                errors = errors + 1;
                $display("FAIL invariant_dut1: got pu=%b en=%b rdy=%b required en=>pu and rdy=>en",
                         pu1, en1, rdy1);
            end
        end
    end

    task automatic add(input logic s, input logic r, input logic q, input int n,
                       input logic [3:0] e, input logic [15:0] w, input string nm);
        vec_t v;
        v.sel = s; v.rst = r; v.req = q; v.n = n;
        v.exp_o = e; v.exp_wake = w; v.name = nm;
        vecs.push_back(v);
    endtask

    // Drive one vector (called on a falling edge), advance, then compare.
    task automatic step(input vec_t v);
        vec_t e;
        logic [3:0]  got_o;
        logic [15:0] got_w;
        if (v.sel) begin
            reset1 = v.rst;
            req1   = v.req;
        end else begin
            reset0 = v.rst;
            req0   = v.req;
        end
        exp_q.push_back(v);
        repeat (v.n) @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        got_o = e.sel ? {pu1, en1, rdy1, busy1} : {pu0, en0, rdy0, busy0};
        got_w = e.sel ? wake1 : wake0;
        checks = checks + 1;
        if ((got_o !== e.exp_o) || (got_w !== e.exp_wake)) begin
            errors = errors + 1;
            $display("FAIL %s: got {pu,en,rdy,busy}=%b wake=%h, required %b wake=%h",
                     e.name, got_o, got_w, e.exp_o, e.exp_wake);
        end
    endtask

    initial begin
        reset0 = 1'b1; req0 = 1'b0;
        reset1 = 1'b1; req1 = 1'b1;

        // dut1: boot into ON, hold, drain, reset mid-drain.
        add(1, 1, 1, 2, 4'b1110, 16'h0000, "r1_reset_on");
        add(1, 0, 1, 5, 4'b1110, 16'h0000, "r1_hold_on");
        add(1, 0, 0, 2, 4'b1110, 16'h0000, "r1_drop_sync_latency");
        add(1, 0, 0, 1, 4'b1101, 16'h0000, "r1_drain_entry");
        add(1, 1, 0, 1, 4'b1110, 16'h0000, "r1_reset_mid_drain");
        // dut0: reset into OFF, power-up with 3-cycle request latency and 10-cycle settle.
        add(0, 1, 0, 2, 4'b0000, 16'h0000, "reset_off");
        add(0, 0, 1, 2, 4'b0000, 16'h0000, "pu_sync_latency");
        add(0, 0, 1, 1, 4'b1001, 16'h0000, "pu_rise_cycle3");
        add(0, 0, 1, 9, 4'b1001, 16'h0000, "pu_settle_cycle12");
        add(0, 0, 1, 1, 4'b1110, 16'h0001, "on_entry_cycle13");
        // Power-down: ready falls 3 cycles after request drop, enable/powerup 4 later.
        add(0, 0, 0, 2, 4'b1110, 16'h0001, "on_before_drain");
        add(0, 0, 0, 1, 4'b1101, 16'h0001, "drain_entry");
        add(0, 0, 0, 3, 4'b1101, 16'h0001, "drain_hold");
        add(0, 0, 0, 1, 4'b0000, 16'h0001, "off_after_drain");
        // Request right after OFF entry waits for the off-timer.
        add(0, 0, 1, 8, 4'b0000, 16'h0001, "min_off_hold");
        add(0, 0, 1, 1, 4'b1001, 16'h0001, "pu_after_min_off");
        // Abort 5 cycles into PU_WAIT.
        add(0, 0, 1, 5, 4'b1001, 16'h0001, "pu_wait_5");
        add(0, 0, 0, 2, 4'b1001, 16'h0001, "abort_sync_latency");
        add(0, 0, 0, 1, 4'b0000, 16'h0001, "abort_to_off");
        // Full power-up again, then re-acquire from DRAIN.
        add(0, 0, 1, 9, 4'b1001, 16'h0001, "pu_again");
        add(0, 0, 1, 9, 4'b1001, 16'h0001, "pu_again_settle");
        add(0, 0, 1, 1, 4'b1110, 16'h0002, "on_again");
        add(0, 0, 0, 3, 4'b1101, 16'h0002, "drain_again");
        add(0, 0, 0, 1, 4'b1101, 16'h0002, "drain_1");
        add(0, 0, 1, 2, 4'b1101, 16'h0002, "drain_reassert_sync");
        add(0, 0, 1, 1, 4'b1110, 16'h0003, "reacquire_on");

        @(negedge clk);
        mon_en = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i]);
        end

        // Wake counter saturation: preload 16'hFFFE while ON, then two re-acquires.
        force dut0.wake_q = 16'hFFFE;
        @(posedge clk);
        @(negedge clk);
        release dut0.wake_q;
        vecs.delete();
        add(0, 0, 1, 1, 4'b1110, 16'hFFFE, "wake_preload");
        for (int k = 0; k < 2; k++) begin
            add(0, 0, 0, 3, 4'b1101, (k == 0) ? 16'hFFFE : 16'hFFFF, "sat_drain");
            add(0, 0, 1, 2, 4'b1101, (k == 0) ? 16'hFFFE : 16'hFFFF, "sat_drain_sync");
            add(0, 0, 1, 1, 4'b1110, 16'hFFFF, "sat_reacquire");
        end
        // Reset mid-PU_WAIT clears everything next cycle with no drain.
        add(0, 0, 0, 3, 4'b1101, 16'hFFFF, "pre_reset_drain");
        add(0, 0, 0, 4, 4'b0000, 16'hFFFF, "pre_reset_off");
        add(0, 0, 1, 9, 4'b1001, 16'hFFFF, "pre_reset_pu");
        add(0, 0, 1, 2, 4'b1001, 16'hFFFF, "pre_reset_pu_hold");
        add(0, 1, 1, 1, 4'b0000, 16'h0000, "reset_mid_pu_wait");
        add(0, 0, 0, 3, 4'b0000, 16'h0000, "stay_off_after_reset");
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i]);
        end

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
